// File: rtl/lottery_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Package : lottery_pkg
// Shared types and constants for the lottery draw generator and ticket checker.
// Rev     : 1.0
// ---------------------------------------------------------------------------
package lottery_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DRAW = 3'd1,
        ST_SEND = 3'd2,
        ST_GAP  = 3'd3,
        ST_FIN  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam int NUM_DIGITS = 5;

    // Feedback taps 15, 13, 12, 10 of the draw LFSR
    localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

    // Active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_P;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lottery_lfsr16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : lottery_lfsr16
// 16-bit Fibonacci LFSR with seed load; a zero load value selects SEED.
// Rev     : 1.0
// ---------------------------------------------------------------------------
module lottery_lfsr16
    import lottery_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic        w_feedback;

    assign w_feedback = ^(r_q & LFSR_TAP_MASK);

    // The all-zero state would lock the register, so it is never loaded
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= SEED;
        end else if (load) begin
            r_q <= (load_val == 16'h0000) ? SEED : load_val;
        end else if (step) begin
            r_q <= {r_q[14:0], w_feedback};
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/lottery_draw.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : lottery_draw
// Draws five decimal digits and sends them on the num/insert/finish protocol.
// Define LOTTERY_DRAW_HEX_EN to drive HEX4..HEX0 and LEDR from the draw.
// Rev     : 1.0
// ---------------------------------------------------------------------------
module lottery_draw
    import lottery_pkg::*;
#(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          GAP_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [3:0]  num,
    output logic        insert,
    output logic        finish,
    output logic        busy,
    output logic        done,
    output logic [9:0]  LEDR,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX0
);

    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);
    localparam logic [2:0] LAST_INDEX = 3'(NUM_DIGITS - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] w_lfsr;
    logic [3:0]  w_cand;
    logic        w_accept;
    logic        w_ctrl_ok;
    logic        w_load;
    logic        w_begin;
    logic        w_step;
    logic        w_gap_end;
    logic        w_last_digit;
    logic [2:0]  r_idx;
    logic [3:0]  r_gap_cnt;
    logic [3:0]  r_num;
    logic        w_unused_lfsr_hi;

    assign w_cand       = w_lfsr[3:0];
    assign w_accept     = (w_cand <= 4'd9);
    assign w_ctrl_ok    = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_load       = w_ctrl_ok && seed_load;
    assign w_begin      = w_ctrl_ok && start;
    assign w_step       = (r_state == ST_DRAW);
    assign w_gap_end    = (r_gap_cnt == GAP_LAST);
    assign w_last_digit = (r_idx == LAST_INDEX);

    // Only the low nibble is a candidate; the rest is LFSR history
    assign w_unused_lfsr_hi = ^w_lfsr[15:4];

    lottery_lfsr16 #(
        .SEED     (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (seed),
        .step     (w_step),
        .q        (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next_state = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (w_accept) begin
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                w_next_state = ST_GAP;
            end
            ST_GAP: begin
                if (w_gap_end) begin
                    w_next_state = w_last_digit ? ST_FIN : ST_DRAW;
                end
            end
            ST_FIN: begin
                w_next_state = ST_DONE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        insert = 1'b0;
        finish = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_DRAW: busy = 1'b1;
            ST_SEND: begin
                busy   = 1'b1;
                insert = 1'b1;
            end
            ST_GAP:  busy = 1'b1;
            ST_FIN: begin
                busy   = 1'b1;
                finish = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // The gap counter idles at zero so every GAP phase starts from a clean count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx     <= 3'd0;
            r_gap_cnt <= 4'd0;
            r_num     <= 4'd0;
        end else begin
            if (w_begin) begin
                r_idx <= 3'd0;
            end else if ((r_state == ST_GAP) && w_gap_end && !w_last_digit) begin
                r_idx <= r_idx + 3'd1;
            end

            if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + 4'd1;
            end else begin
                r_gap_cnt <= 4'd0;
            end

            if (w_step && w_accept) begin
                r_num <= w_cand;
            end
        end
    end

    assign num = r_num;

`ifdef LOTTERY_DRAW_HEX_EN
    logic [3:0]            r_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_valid;
    logic [6:0]            w_seg   [NUM_DIGITS];

    // r_valid fills in order, so it doubles as the LEDR thermometer
    always_ff @(posedge clk) begin
        if (reset || w_begin) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_digit[i] <= 4'd0;
            end
        end else if (w_step && w_accept) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (r_idx == 3'(i)) begin
                    r_digit[i] <= w_cand;
                    r_valid[i] <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
            assign w_seg[gi] = r_valid[gi] ? seg_decode(r_digit[gi]) : SEG_DASH;
        end
    endgenerate

    assign HEX4 = w_seg[0];
    assign HEX3 = w_seg[1];
    assign HEX2 = w_seg[2];
    assign HEX1 = w_seg[3];
    assign HEX0 = w_seg[4];
    assign LEDR = {{(10 - NUM_DIGITS){1'b0}}, r_valid};
`else
    assign HEX4 = SEG_BLANK;
    assign HEX3 = SEG_BLANK;
    assign HEX2 = SEG_BLANK;
    assign HEX1 = SEG_BLANK;
    assign HEX0 = SEG_BLANK;
    assign LEDR = 10'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lottery_draw.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_lottery_draw
// Scoreboard bench for lottery_draw with gap lengths 3 (main), 1 and 15.
// Rev     : 1.0
// ---------------------------------------------------------------------------
module tb_lottery_draw;

    typedef struct {
        logic [3:0] num;
        int         n;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start_a;
    logic        seed_load;
    logic [15:0] seed;

    logic [3:0]  num_a    [3];
    logic        insert_a [3];
    logic        finish_a [3];
    logic        busy_a   [3];
    logic        done_a   [3];
    logic [9:0]  led_a    [3];
    logic [34:0] hex_a    [3];

    logic [15:0] m_lfsr [3];
    int          vectors     = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            logic [6:0] h4, h3, h2, h1, h0;
            logic [3:0] nm;
            logic       ins, fin, bsy, dn;
            logic [9:0] led;

            lottery_draw #(
                .SEED       (16'hACE1),
                .GAP_CYCLES ((g == 0) ? 3 : ((g == 1) ? 1 : 15))
            ) dut (
                .clk       (clk),
                .reset     (reset),
                .start     (start_a[g]),
                .seed_load ((g == 0) ? seed_load : 1'b0),
                .seed      ((g == 0) ? seed : 16'h0000),
                .num       (nm),
                .insert    (ins),
                .finish    (fin),
                .busy      (bsy),
                .done      (dn),
                .LEDR      (led),
                .HEX4      (h4),
                .HEX3      (h3),
                .HEX2      (h2),
                .HEX1      (h1),
                .HEX0      (h0)
            );

            assign num_a[g]    = nm;
            assign insert_a[g] = ins;
            assign finish_a[g] = fin;
            assign busy_a[g]   = bsy;
            assign done_a[g]   = dn;
            assign led_a[g]    = led;
            assign hex_a[g]    = {h4, h3, h2, h1, h0};
        end
    endgenerate

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Expected {HEX4..HEX0} after cnt digits, digit j held in gd[4j+:4]
    function automatic logic [34:0] exp_hex(input logic [19:0] gd, input int cnt);
        logic [34:0] r;
        r = '1;
`ifdef LOTTERY_DRAW_HEX_EN
        for (int j = 0; j < 5; j++) begin
            r[34 - 7 * j -: 7] = (j < cnt) ? exp_seg(gd[4 * j +: 4]) : 7'b0111111;
        end
`endif
        return r;
    endfunction

    function automatic logic [9:0] exp_led(input int cnt);
`ifdef LOTTERY_DRAW_HEX_EN
        return (10'd1 << cnt) - 10'd1;
`else
        return (cnt > 99) ? 10'h3FF : 10'd0;
`endif
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        start_a   = 3'b000;
        seed_load = 1'b0;
        seed      = 16'h0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) m_lfsr[i] = 16'hACE1;
    endtask

    // One draw on instance sel. Expected digits and insert/finish times are
    // precomputed from the LFSR model; n counts cycles after the start edge.
    task automatic run_draw(input int sel, input int gap, input bit do_load,
                            input logic [15:0] ld_seed, input bit poke, input int abort_at);
        exp_t        exp_q[$];
        exp_t        e;
        logic [15:0] l;
        logic [19:0] gd;
        int          off, r, fin_n, seen;
        bit          got_fin, stop, quiet;

        if (do_load) m_lfsr[sel] = (ld_seed == 16'h0000) ? 16'hACE1 : ld_seed;
        l   = m_lfsr[sel];
        off = 0;
        for (int d = 0; d < 5; d++) begin
            r = 0;
            while (l[3:0] > 4'd9 && r < 100) begin
                l = lfsr_next(l);
                r++;
            end
            e.num = l[3:0];
            e.n   = off + r + 1;
            exp_q.push_back(e);
            l   = lfsr_next(l);
            off = off + r + 2 + gap;
        end
        fin_n       = off;
        m_lfsr[sel] = l;

        @(negedge clk);
        start_a[sel] = 1'b1;
        if (do_load) begin
            seed_load = 1'b1;
            seed      = ld_seed;
        end
        @(negedge clk);
        start_a[sel] = 1'b0;
        seed_load    = 1'b0;

        gd = '0; seen = 0; got_fin = 1'b0; stop = 1'b0;
        for (int n = 0; n <= fin_n + 8 && !got_fin && !stop; n++) begin
            if (n > 0) @(negedge clk);
            if (poke) begin
                if (n == 3 || n == fin_n - 1) begin
                    start_a[0] = 1'b1;
                    seed_load  = 1'b1;
                    seed       = 16'h1234;
                end else begin
                    start_a[0] = 1'b0;
                    seed_load  = 1'b0;
                end
            end
            if (n == 0) begin
                vectors++;
                if (busy_a[sel] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy_in_draw dut%0d: got %b, want 1", sel, busy_a[sel]);
                end
            end
            vectors++;
            if (insert_a[sel] && finish_a[sel]) begin
                miscompares++;
                $display("FAIL strobe_overlap dut%0d n=%0d: insert=1 finish=1, want not both", sel, n);
            end
            if (insert_a[sel]) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_insert dut%0d n=%0d: got insert, want none", sel, n);
                end else begin
                    e = exp_q.pop_front();
                    gd[4 * seen +: 4] = e.num;
                    seen++;
                    if (num_a[sel] !== e.num) begin
                        miscompares++;
                        $display("FAIL digit%0d_num dut%0d: got %0d, want %0d", seen - 1, sel, num_a[sel], e.num);
                    end
                    vectors++;
                    if (n !== e.n) begin
                        miscompares++;
                        $display("FAIL digit%0d_time dut%0d: got cycle %0d, want %0d", seen - 1, sel, n, e.n);
                    end
                    vectors++;
                    if (hex_a[sel] !== exp_hex(gd, seen)) begin
                        miscompares++;
                        $display("FAIL digit%0d_hex dut%0d: got %h, want %h", seen - 1, sel, hex_a[sel], exp_hex(gd, seen));
                    end
                    vectors++;
                    if (led_a[sel] !== exp_led(seen)) begin
                        miscompares++;
                        $display("FAIL digit%0d_ledr dut%0d: got %b, want %b", seen - 1, sel, led_a[sel], exp_led(seen));
                    end
                end
                if (seen == abort_at) stop = 1'b1;
            end
            if (finish_a[sel]) begin
                got_fin = 1'b1;
                vectors++;
                if (n !== fin_n) begin
                    miscompares++;
                    $display("FAIL finish_time dut%0d: got cycle %0d, want %0d", sel, n, fin_n);
                end
                vectors++;
                if (seen !== 5 || exp_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL insert_count dut%0d: got %0d, want 5", sel, seen);
                end
            end
        end
        start_a[sel] = 1'b0;
        seed_load    = 1'b0;

        if (stop) begin
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            vectors++;
            if (insert_a[sel] !== 1'b0 || finish_a[sel] !== 1'b0 || busy_a[sel] !== 1'b0 || done_a[sel] !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_outputs dut%0d: got ins=%b fin=%b busy=%b done=%b, want all 0",
                         sel, insert_a[sel], finish_a[sel], busy_a[sel], done_a[sel]);
            end
            vectors++;
            if (hex_a[sel] !== exp_hex(20'h0, 0) || led_a[sel] !== 10'd0) begin
                miscompares++;
                $display("FAIL abort_display dut%0d: got hex=%h led=%b, want hex=%h led=0",
                         sel, hex_a[sel], led_a[sel], exp_hex(20'h0, 0));
            end
            reset = 1'b0;
            for (int i = 0; i < 3; i++) m_lfsr[i] = 16'hACE1;
            quiet = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (insert_a[sel] !== 1'b0 || finish_a[sel] !== 1'b0) quiet = 1'b0;
            end
            vectors++;
            if (!quiet) begin
                miscompares++;
                $display("FAIL abort_quiet dut%0d: got a strobe after reset, want none", sel);
            end
        end else if (!got_fin) begin
            vectors++;
            miscompares++;
            $display("FAIL finish_timeout dut%0d: got no finish by cycle %0d, want cycle %0d", sel, fin_n + 8, fin_n);
        end else begin
            @(negedge clk);
            vectors++;
            if (done_a[sel] !== 1'b1 || busy_a[sel] !== 1'b0) begin
                miscompares++;
                $display("FAIL done_state dut%0d: got done=%b busy=%b, want done=1 busy=0", sel, done_a[sel], busy_a[sel]);
            end
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            vectors++;
            if (insert_a[s] !== 1'b0 || finish_a[s] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_strobes dut%0d: got ins=%b fin=%b, want 0 0", s, insert_a[s], finish_a[s]);
            end
            vectors++;
            if (busy_a[s] !== 1'b0 || done_a[s] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_status dut%0d: got busy=%b done=%b, want 0 0", s, busy_a[s], done_a[s]);
            end
            vectors++;
            if (num_a[s] !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_num dut%0d: got %0d, want 0", s, num_a[s]);
            end
            vectors++;
            if (led_a[s] !== 10'd0) begin
                miscompares++;
                $display("FAIL reset_ledr dut%0d: got %b, want 0", s, led_a[s]);
            end
            vectors++;
            if (hex_a[s] !== exp_hex(20'h0, 0)) begin
                miscompares++;
                $display("FAIL reset_hex dut%0d: got %h, want %h", s, hex_a[s], exp_hex(20'h0, 0));
            end
        end
    endtask

    task automatic test_first_digit();
        run_draw(0, 3, 1'b0, 16'h0000, 1'b0, 0);
    endtask

    task automatic test_gap_replay();
        run_draw(1, 1, 1'b0, 16'h0000, 1'b0, 0);
        run_draw(2, 15, 1'b0, 16'h0000, 1'b0, 0);
    endtask

    task automatic test_seed_reject();
        @(negedge clk);
        seed_load = 1'b1;
        seed      = 16'h000F;
        @(negedge clk);
        seed_load = 1'b0;
        m_lfsr[0] = 16'h000F;
        run_draw(0, 3, 1'b0, 16'h0000, 1'b0, 0);
        run_draw(0, 3, 1'b1, 16'h000F, 1'b0, 0);
    endtask

    task automatic test_busy_ignore();
        run_draw(0, 3, 1'b0, 16'h0000, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        run_draw(0, 3, 1'b0, 16'h0000, 1'b0, 0);
        run_draw(0, 3, 1'b0, 16'h0000, 1'b0, 0);
    endtask

    task automatic test_seed_zero();
        run_draw(0, 3, 1'b1, 16'h0000, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        run_draw(0, 3, 1'b0, 16'h0000, 1'b0, 3);
        run_draw(0, 3, 1'b0, 16'h0000, 1'b0, 0);
    endtask

    initial begin
        do_reset();
        test_reset();
        test_first_digit();
        test_gap_replay();
        test_seed_reject();
        test_busy_ignore();
        test_back_to_back();
        test_seed_zero();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lottery_draw.md
# lottery_draw

Draw generator and transmitter for the lottery game. It produces five pseudo-random decimal digits from a 16-bit LFSR, rejecting nibbles above 9. It sends the digits on the same `num`/`insert`/`finish` protocol the ticket checker consumes, so it can drive a checker directly or feed the board displays with the official draw.

## Interface
- `SEED`, default 16'hACE1: LFSR value after reset, and the substitute when a zero seed is loaded.
- `GAP_CYCLES`, default 3: idle cycles after each `insert` pulse. Legal range 1..15.
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a draw. Honoured only in IDLE or DONE.
- `seed_load` input 1: load `seed` into the LFSR. Honoured only in IDLE or DONE.
- `seed` input 16: seed value.
- `num` output 4: current digit. Valid while `insert` is high; held until the next digit.
- `insert` output 1: one-cycle strobe per digit.
- `finish` output 1: one-cycle strobe after the fifth digit.
- `busy` output 1: high in DRAW, SEND, GAP and FIN.
- `done` output 1: high in DONE.
- `LEDR` output 10: thermometer of the digit index. Bit i is set when i+1 digits have been sent.
- `HEX4..HEX0` output 7 each: drawn digits, active-low segments, with digit 0 on HEX4.

## Operation
States: IDLE, DRAW, SEND, GAP, FIN, DONE.

**IDLE**
- `seed_load` loads `seed` into the LFSR. A zero `seed` loads `SEED` instead.
- `start` clears the digit index and the digit registers, then moves to DRAW.
- If `seed_load` and `start` arrive in the same cycle, the load applies first and the draw uses the new seed.

**DRAW**
- Each cycle, `cand = lfsr[3:0]`.
- The LFSR shifts every DRAW cycle: `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
- If `cand <= 9`: latch `cand` into `digit[idx]` and `num`, then go to SEND.
- Otherwise stay in DRAW (rejection). There is no upper bound on rejected cycles.

**SEND**
- `insert = 1` for one cycle, then go to GAP with the gap counter at 0.

**GAP**
- Count `GAP_CYCLES` cycles.
- On expiry: if `idx == 4`, go to FIN; otherwise `idx++` and go to DRAW.

**FIN**
- `finish = 1` for one cycle, then go to DONE.

**DONE**
- `done` is held high.
- `start` starts a new draw, continuing from the current LFSR state.
- `seed_load` behaves as in IDLE.

**Other rules**
- The LFSR holds in every state except DRAW and seed loads.
- `start` and `seed_load` are ignored while `busy` is high.
- `insert` and `finish` are never high in the same cycle.

**Reset values**
- State IDLE, LFSR = `SEED`, `idx = 0`, digits 0.
- `num = 0`, `insert = 0`, `finish = 0`, `busy = 0`, `done = 0`, `LEDR = 0`.
- HEX outputs show dash (7'b0111111).
- Reset mid-draw aborts immediately. No further strobes are emitted.

## Timing
- `start` sampled at edge k: state is DRAW after edge k.
- With no rejection:
  - `insert` is high in the cycle after edge k+1.
  - Digits are spaced `2 + GAP_CYCLES` cycles apart.
  - `finish` is high `5 × (2 + GAP_CYCLES)` cycles after edge k.
  - `done` rises one cycle after `finish`.
- Each rejected nibble adds one cycle before the corresponding `insert`.
- `insert`, `finish`, `busy` and `done` are decoded from the registered state; no combinational path from inputs.
- HEX digit i updates in the same cycle its `insert` is high.
- Undrawn digits show dash.

## Configuration
- `LOTTERY_DRAW_HEX_EN` defined:
  - HEX4..HEX0 decode the digit registers: 0 = 7'b1000000 … 9 = 7'b0010000, dash = 7'b0111111.
  - `LEDR` drives the thermometer.
- Not defined: HEX4..HEX0 are tied to 7'b1111111 (blank) and `LEDR` to 0. The protocol outputs are unchanged.

## Structure
- Shared package `lottery_pkg` holds:
  - the state enum,
  - the 7-segment constants (digits, dash, 'P', blank),
  - the LFSR tap mask,
  - `NUM_DIGITS = 5`.
- The checker uses the same package.
- One sub-module, `lottery_lfsr16`: `load`, `load_val`, `step`, outputs `q`, with the zero-seed substitution inside.
- The segment decode is a package function, not a module.

## Test plan
- Reset, then `start` with default `SEED` 16'hACE1. First `lfsr[3:0] = 1` is accepted: `insert` high 2 cycles after `start` with `num = 1`.
- `seed_load` with `seed = 16'h000F`, then `start`. Nibbles F, E, C are rejected and 8 is accepted (LFSR 16'h0078): `insert` with `num = 8` arrives 5 cycles after `start`.
- Full draw: exactly 5 `insert` pulses, each `num <= 9`, followed by one `finish`. Then `done` = 1 and `busy` = 0. Check the pulse spacing against the same draw replayed with `GAP_CYCLES` = 1 and 15.
- `start` and `seed_load` pulsed while `busy` is high: no effect on the sequence or the LFSR. `seed_load` with `seed = 0` loads `SEED`.
- Reset asserted in GAP after the third digit:
  - next cycle `insert = 0`, `finish = 0` and state IDLE;
  - HEX all dash;
  - a subsequent `start` reproduces the first post-reset sequence.
- Back-to-back draws: `start` in DONE begins a new draw from the current LFSR state. Connect to the ticket checker and confirm the checker's displays match the transmitted digits.
